// File: rtl/hcms_frame_driver_if.sv
// Host-write and hcms_serial-side signals of the frame driver, bundled.
// slave = the frame driver; master = the host / serializer side.
interface hcms_frame_driver_if;
    logic       WR_EN;
    logic [2:0] WR_ADDR;
    logic [4:0] WR_CHAR;
    logic       SER_READY;
    logic [7:0] SER_DATA;
    logic       SER_CMD;
    logic       SER_LOAD;
    logic       SER_DS_RESET;
    logic       BUSY;
    logic       FRAME_DONE;

    modport slave (
        input  WR_EN, WR_ADDR, WR_CHAR, SER_READY,
        output SER_DATA, SER_CMD, SER_LOAD, SER_DS_RESET, BUSY, FRAME_DONE
    );

    modport master (
        output WR_EN, WR_ADDR, WR_CHAR, SER_READY,
        input  SER_DATA, SER_CMD, SER_LOAD, SER_DS_RESET, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/hcms_frame_driver.sv
// HCMS-29xx frame driver: power-up sequence (DS_RESET, two control words),
// then full dot-register refresh from a 5x7 font whenever the glyph buffer changes.
module hcms_frame_driver #(
    parameter int         NUM_CHARS    = 4,
    parameter logic [7:0] CTRL_W1      = 8'h81,
    parameter logic [7:0] CTRL_W2      = 8'h79,
    parameter int         RESET_CYCLES = 16
) (
    input  logic                CLK_i,
    input  logic                RST_i,
    hcms_frame_driver_if.slave  bus
);
    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_CFG1 = 3'd1;
    localparam logic [2:0] S_CFG2 = 3'd2;
    localparam logic [2:0] S_IDLE = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    localparam logic [1:0] H_WAIT = 2'd0;
    localparam logic [1:0] H_LOAD = 2'd1;
    localparam logic [1:0] H_ACK  = 2'd2;

    logic [2:0]                r_state;
    logic [1:0]                r_hs;
    logic [15:0]               r_rst_cnt;
    logic [NUM_CHARS-1:0][4:0] r_buf;
    logic [NUM_CHARS-1:0][4:0] r_snap;
    logic                      r_dirty;
    logic [2:0]                r_char;
    logic [2:0]                r_col;
    logic                      r_ready_q;
    logic                      r_armed;
    logic [7:0]                r_data;
    logic                      r_cmd;
    logic                      r_load;
    logic                      r_ds;
    logic                      r_done;

    logic                      w_wr_ok;
    logic                      w_rise;
    logic [4:0]                w_glyph;
    logic [7:0]                w_font;

    // Column-major 5x7 font; bit 0 is the top row. Codes above 16 are dark.
    function automatic logic [7:0] font(input logic [4:0] g, input logic [2:0] c);
        logic [39:0] cols;
        case (g)
            5'd0:    cols = 40'h3E_51_49_45_3E;
            5'd1:    cols = 40'h00_42_7F_40_00;
            5'd2:    cols = 40'h42_61_51_49_46;
            5'd3:    cols = 40'h21_41_45_4B_31;
            5'd4:    cols = 40'h18_14_12_7F_10;
            5'd5:    cols = 40'h27_45_45_45_39;
            5'd6:    cols = 40'h3C_4A_49_49_30;
            5'd7:    cols = 40'h01_71_09_05_03;
            5'd8:    cols = 40'h36_49_49_49_36;
            5'd9:    cols = 40'h06_49_49_29_1E;
            5'd10:   cols = 40'h7E_11_11_11_7E;
            5'd11:   cols = 40'h7F_49_49_49_36;
            5'd12:   cols = 40'h3E_41_41_41_22;
            5'd13:   cols = 40'h7F_41_41_22_1C;
            5'd14:   cols = 40'h7F_49_49_49_41;
            5'd15:   cols = 40'h7F_09_09_09_01;
            default: cols = 40'h0;
        endcase
        case (c)
            3'd0:    font = cols[39:32];
            3'd1:    font = cols[31:24];
            3'd2:    font = cols[23:16];
            3'd3:    font = cols[15:8];
            3'd4:    font = cols[7:0];
            default: font = 8'h00;
        endcase
    endfunction

    assign w_wr_ok = bus.WR_EN && ({1'b0, bus.WR_ADDR} < 4'(NUM_CHARS));
    assign w_rise  = bus.SER_READY && !r_ready_q;
    assign w_font  = font(w_glyph, r_col);

    // Pick the snapshot glyph for the character currently being shifted out.
    always_comb begin
        w_glyph = 5'd16;
        for (int i = 0; i < NUM_CHARS; i++)
            if (r_char == 3'(i)) w_glyph = r_snap[i];
    end

    // Live glyph buffer; out-of-range slots are silently dropped.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_buf <= {NUM_CHARS{5'd16}};
        end else begin
            for (int i = 0; i < NUM_CHARS; i++)
                if (w_wr_ok && bus.WR_ADDR == 3'(i)) r_buf[i] <= bus.WR_CHAR;
        end
    end

    // Dirty flag: a write wins over the clear taken in S_IDLE.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i)                  r_dirty <= 1'b1;
        else if (w_wr_ok)           r_dirty <= 1'b1;
        else if (r_state == S_IDLE) r_dirty <= 1'b0;
    end

    // READY history for edge detection; starts high so READY already high after reset is no edge.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) r_ready_q <= 1'b1;
        else       r_ready_q <= bus.SER_READY;
    end

    // Main sequencer plus per-byte handshake. A READY rise is remembered in r_armed
    // so a rise seen while idle still releases the first byte of the next frame.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_state   <= S_RST;
            r_hs      <= H_WAIT;
            r_rst_cnt <= '0;
            r_snap    <= {NUM_CHARS{5'd16}};
            r_char    <= '0;
            r_col     <= '0;
            r_armed   <= 1'b0;
            r_data    <= '0;
            r_cmd     <= 1'b0;
            r_load    <= 1'b1;
            r_ds      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rise) r_armed <= 1'b1;
            case (r_state)
                S_RST: begin
                    if (r_rst_cnt == 16'(RESET_CYCLES - 1)) begin
                        r_ds    <= 1'b0;
                        r_state <= S_CFG1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 16'd1;
                    end
                end
                S_IDLE: begin
                    if (r_dirty) begin
                        r_snap  <= r_buf;
                        r_char  <= 3'(NUM_CHARS - 1);
                        r_col   <= '0;
                        r_hs    <= H_WAIT;
                        r_state <= S_DATA;
                    end
                end
                S_CFG1, S_CFG2, S_DATA: begin
                    case (r_hs)
                        H_WAIT: begin
                            if (r_armed || w_rise) begin
                                r_armed <= 1'b0;
                                r_load  <= 1'b0;
                                r_hs    <= H_LOAD;
                                if (r_state == S_CFG1) begin
                                    r_data <= CTRL_W1;
                                    r_cmd  <= 1'b1;
                                end else if (r_state == S_CFG2) begin
                                    r_data <= CTRL_W2;
                                    r_cmd  <= 1'b1;
                                end else begin
                                    r_data <= w_font;
                                    r_cmd  <= 1'b0;
                                end
                            end
                        end
                        H_LOAD: begin
                            if (!bus.SER_READY) begin
                                r_load <= 1'b1;
                                r_hs   <= H_ACK;
                            end
                        end
                        default: begin
                            r_hs <= H_WAIT;
                            if (r_state == S_CFG1) begin
                                r_state <= S_CFG2;
                            end else if (r_state == S_CFG2) begin
                                r_state <= S_IDLE;
                            end else if (r_char == 3'd0 && r_col == 3'd4) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else if (r_col == 3'd4) begin
                                r_col  <= '0;
                                r_char <= r_char - 3'd1;
                            end else begin
                                r_col <= r_col + 3'd1;
                            end
                        end
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.SER_DATA     = r_data;
    assign bus.SER_CMD      = r_cmd;
    assign bus.SER_LOAD     = r_load;
    assign bus.SER_DS_RESET = r_ds;
    assign bus.BUSY         = (r_state != S_IDLE);
    assign bus.FRAME_DONE   = r_done;
endmodule

// File: tb/tb_hcms_frame_driver.sv
// Bench for hcms_frame_driver: behavioural hcms_serial model, byte capture,
// and a glyph-buffer reference model that predicts whole frames.
module tb_hcms_frame_driver;
    localparam int NC = 4;

    logic CLK_i = 1'b0;
    logic RST_i = 1'b1;

    hcms_frame_driver_if bus();

    hcms_frame_driver #(
        .NUM_CHARS(NC), .CTRL_W1(8'h81), .CTRL_W2(8'h79), .RESET_CYCLES(16)
    ) dut (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .bus   (bus)
    );

    always #5 CLK_i = ~CLK_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference font: column bytes per glyph code 0..16.
    logic [7:0] FONT [17][5] = '{
        '{8'h3E,8'h51,8'h49,8'h45,8'h3E}, '{8'h00,8'h42,8'h7F,8'h40,8'h00},
        '{8'h42,8'h61,8'h51,8'h49,8'h46}, '{8'h21,8'h41,8'h45,8'h4B,8'h31},
        '{8'h18,8'h14,8'h12,8'h7F,8'h10}, '{8'h27,8'h45,8'h45,8'h45,8'h39},
        '{8'h3C,8'h4A,8'h49,8'h49,8'h30}, '{8'h01,8'h71,8'h09,8'h05,8'h03},
        '{8'h36,8'h49,8'h49,8'h49,8'h36}, '{8'h06,8'h49,8'h49,8'h29,8'h1E},
        '{8'h7E,8'h11,8'h11,8'h11,8'h7E}, '{8'h7F,8'h49,8'h49,8'h49,8'h36},
        '{8'h3E,8'h41,8'h41,8'h41,8'h22}, '{8'h7F,8'h41,8'h41,8'h22,8'h1C},
        '{8'h7F,8'h49,8'h49,8'h49,8'h41}, '{8'h7F,8'h09,8'h09,8'h09,8'h01},
        '{8'h00,8'h00,8'h00,8'h00,8'h00}
    };

    logic [4:0]  mbuf [NC];
    logic [8:0]  cap [$];
    int          fd_cnt = 0;
    int          ds_cnt = 0;

    // serializer model state
    int          ms = 0, mcnt = 0, dd = 2;
    logic [8:0]  cur;
    bit          stall_req = 0, stall_seen = 0, stall_ok = 1;

    function automatic logic [NC*5-1:0] pack_buf();
        logic [NC*5-1:0] v;
        for (int i = 0; i < NC; i++) v[i*5 +: 5] = mbuf[i];
        return v;
    endfunction

    function automatic logic [8:0] exp_byte(input logic [NC*5-1:0] gv, input int idx);
        int ch = NC - 1 - idx / 5;
        logic [4:0] g = gv[ch*5 +: 5];
        if (g > 5'd16) return 9'h000;
        return {1'b0, FONT[g][idx % 5]};
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [NC*5-1:0] gv);
        for (int i = 0; i < NC*5; i++) begin
            if (start + i < cap.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(cap[start+i]), 32'(exp_byte(gv, i)));
            else
                chk($sformatf("%s_missing%0d", tag, i), 32'(cap.size()), 32'(start + i + 1));
        end
    endtask

    // hcms_serial stand-in: READY low during DS_RESET, rises 20 cycles later;
    // drops 2 cycles (or 500 when stalled) after LOAD goes low, rises 20 cycles after that.
    initial begin
        bus.SER_READY = 1'b0;
        forever begin
            @(negedge CLK_i);
            if (RST_i || bus.SER_DS_RESET) begin
                bus.SER_READY = 1'b0; ms = 0; mcnt = 0;
            end else begin
                case (ms)
                    0: begin
                        mcnt++;
                        if (mcnt >= 20) begin bus.SER_READY = 1'b1; ms = 1; end
                    end
                    1: if (!bus.SER_LOAD) begin
                        cur = {bus.SER_CMD, bus.SER_DATA};
                        cap.push_back(cur);
                        mcnt = 0;
                        dd = stall_req ? 500 : 2;
                        if (stall_req) begin stall_req = 0; stall_seen = 1; end
                        ms = 2;
                    end
                    2: begin
                        if (bus.SER_LOAD !== 1'b0 || {bus.SER_CMD, bus.SER_DATA} !== cur) stall_ok = 0;
                        mcnt++;
                        if (mcnt >= dd) begin bus.SER_READY = 1'b0; mcnt = 0; ms = 3; end
                    end
                    default: begin
                        mcnt++;
                        if (mcnt >= 20) begin bus.SER_READY = 1'b1; ms = 1; end
                    end
                endcase
            end
        end
    end

    // FRAME_DONE cycles and DS_RESET-high cycles outside reset.
    initial begin
        forever begin
            @(negedge CLK_i);
            if (!RST_i && bus.FRAME_DONE)   fd_cnt++;
            if (!RST_i && bus.SER_DS_RESET) ds_cnt++;
        end
    end

    task automatic wr(input int a, input int c);
        @(negedge CLK_i);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'(a); bus.WR_CHAR = 5'(c);
        if (a < NC) mbuf[a] = 5'(c);
    endtask

    task automatic wr_idle();
        @(negedge CLK_i);
        bus.WR_EN = 1'b0;
    endtask

    task automatic wait_caps(input int n, input string tag);
        int k = 0;
        while (cap.size() < n && k < 5000) begin @(negedge CLK_i); k++; end
        if (cap.size() < n) chk({tag, "_timeout"}, 32'(cap.size()), 32'(n));
    endtask

    task automatic settle(input string tag);
        int quiet = 0, k = 0;
        while (quiet < 60 && k < 20000) begin
            @(negedge CLK_i); k++;
            if (bus.BUSY) quiet = 0; else quiet++;
        end
        if (quiet < 60) chk({tag, "_settle_timeout"}, 32'(k), 32'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data"}, 32'(bus.SER_DATA), 32'h0);
        chk({tag, "_cmd"},  32'(bus.SER_CMD), 32'h0);
        chk({tag, "_load"}, 32'(bus.SER_LOAD), 32'h1);
        chk({tag, "_ds"},   32'(bus.SER_DS_RESET), 32'h1);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'h1);
        chk({tag, "_fd"},   32'(bus.FRAME_DONE), 32'h0);
    endtask

    // Checks the power-up sequence and a blank frame after a reset release.
    task automatic check_powerup(input string tag);
        int fd0 = fd_cnt;
        wait_caps(2 + NC*5, tag);
        settle(tag);
        chk({tag, "_ds_cycles"}, 32'(ds_cnt), 32'd16);
        chk({tag, "_cfg1"}, 32'(cap.size() > 0 ? cap[0] : 9'h0), 32'h181);
        chk({tag, "_cfg2"}, 32'(cap.size() > 1 ? cap[1] : 9'h0), 32'h179);
        check_frame({tag, "_blank"}, 2, pack_buf());
        chk({tag, "_nbytes"}, 32'(cap.size()), 32'(2 + NC*5));
        chk({tag, "_fd"}, 32'(fd_cnt - fd0), 32'd1);
    endtask

    logic [NC*5-1:0] g1, g2;
    logic [7:0] t2_first [5] = '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00};
    logic [7:0] t2_last  [5] = '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36};

    initial begin
        int base, fd0, nw;
        bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_CHAR = '0;
        for (int i = 0; i < NC; i++) mbuf[i] = 5'd16;

        // reset values and power-up
        repeat (3) @(posedge CLK_i);
        @(negedge CLK_i);
        chk_reset_outs("rst");
        ds_cnt = 0;
        @(posedge CLK_i); #1 RST_i = 1'b0;
        check_powerup("t1");

        // two back-to-back writes: first frame sees only the first, the same-cycle
        // write keeps dirty set, so a second frame carries both
        base = cap.size(); fd0 = fd_cnt;
        wr(3, 1); g1 = pack_buf();
        wr(0, 8); g2 = pack_buf();
        wr_idle();
        settle("t2");
        chk("t2_frames", 32'(fd_cnt - fd0), 32'd2);
        check_frame("t2a", base, g1);
        check_frame("t2b", base + NC*5, g2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_first%0d", i), 32'(cap[base + NC*5 + i]), 32'(t2_first[i]));
            chk($sformatf("t2_last%0d", i), 32'(cap[base + 2*NC*5 - 5 + i]), 32'(t2_last[i]));
        end

        // a byte accepted only after 500 cycles: LOAD/DATA must hold, nothing skipped
        base = cap.size(); stall_seen = 0; stall_ok = 1; stall_req = 1;
        wr(1, $urandom_range(0, 15));
        wr_idle();
        settle("t3");
        chk("t3_stalled", 32'(stall_seen), 32'd1);
        chk("t3_hold", 32'(stall_ok), 32'd1);
        chk("t3_nbytes", 32'(cap.size() - base), 32'(NC*5));
        check_frame("t3", base, pack_buf());

        // write during byte 7 of a frame
        base = cap.size(); fd0 = fd_cnt;
        wr(2, $urandom_range(0, 15)); g1 = pack_buf();
        wr_idle();
        wait_caps(base + 7, "t4");
        wr(3, (mbuf[3] == 5'd10) ? 11 : 10); g2 = pack_buf();
        wr_idle();
        settle("t4");
        chk("t4_frames", 32'(fd_cnt - fd0), 32'd2);
        check_frame("t4old", base, g1);
        check_frame("t4new", base + NC*5, g2);

        // out-of-range slot ignored, code 25 renders dark
        base = cap.size(); fd0 = fd_cnt;
        wr(5, 3);
        wr_idle();
        repeat (100) @(negedge CLK_i);
        chk("t6_busy", 32'(bus.BUSY), 32'd0);
        chk("t6_nofd", 32'(fd_cnt - fd0), 32'd0);
        chk("t6_nobytes", 32'(cap.size() - base), 32'd0);
        wr(2, 25);
        wr_idle();
        settle("t6");
        check_frame("t6", base, pack_buf());
        for (int i = 0; i < 5; i++)
            chk($sformatf("t6_dark%0d", i), 32'(cap[base + (NC-1-2)*5 + i]), 32'h0);

        // random writes at random moments; final frame must show the final buffer
        for (int r = 0; r < 6; r++) begin
            base = cap.size(); fd0 = fd_cnt;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                wr($urandom_range(0, 7), $urandom_range(0, 31));
                wr_idle();
                repeat ($urandom_range(0, 300)) @(negedge CLK_i);
            end
            settle($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_bytes", r), 32'(cap.size() - base), 32'((fd_cnt - fd0) * NC*5));
            if (cap.size() >= base + NC*5)
                check_frame($sformatf("rnd%0d", r), cap.size() - NC*5, pack_buf());
        end

        // reset in the middle of a frame
        base = cap.size();
        wr((mbuf[0] == 5'd7) ? 1 : 0, 7);
        wr_idle();
        wait_caps(base + 10, "t5");
        @(negedge CLK_i); RST_i = 1'b1;
        #1 chk_reset_outs("t5rst");
        for (int i = 0; i < NC; i++) mbuf[i] = 5'd16;
        repeat (3) @(posedge CLK_i);
        cap.delete(); ds_cnt = 0;
        @(posedge CLK_i); #1 RST_i = 1'b0;
        check_powerup("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
